accel_pair_scheduler: RTL
=========================

Name: accel_pair_scheduler

Overview:
Sequences the pipelined pairwise acceleration datapath over an N-body set. Generates (i, j) body-index pairs for the body memory and tracks each pair through the datapath latency. Feeds the running per-body acceleration sum back into the datapath's accumulate input at the correct cycle, then streams the final per-body accelerations to the integrator stage. Sits between body-state memory, the acceleration datapath and the position/velocity update block.

Parameters:
N_MAX, 64, maximum body count; sizes the accumulator and scoreboard arrays.
IDX_W, 6, body index width (clog2 N_MAX).
ACC_TAP, 20, cycles from pair issue (cycle t) to the cycle the datapath samples the accumulate inputs.
RES_LAT, 24, cycles from pair issue to the cycle the datapath result is valid; must be greater than ACC_TAP.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; asynchronous, active-low
i_start  in  1  one-cycle pulse; begins a pass when idle
i_n_bodies  in  IDX_W+1  body count, sampled at start; 0..N_MAX
o_busy  out  1  high from accepted start until done pulse
o_done  out  1  one-cycle pulse after last dump beat accepted
o_rd_i  out  IDX_W  body-memory index of body 1 (acted-on body)
o_rd_j  out  IDX_W  body-memory index of body 2 (source body)
o_rd_en  out  1  pair issue strobe; memory presents data to datapath at t+1
o_acc_x, o_acc_y  out  32  running sum for body i of the pair at tap ACC_TAP
i_res_x, i_res_y  in  32  datapath output (acc_in plus contribution)
o_out_valid  out  1  dump beat valid
i_out_ready  in  1  dump beat accepted when valid&ready
o_out_idx  out  IDX_W  body index of dump beat
o_out_ax, o_out_ay  out  32  final acceleration of body o_out_idx

Behaviour:
- Reset: state IDLE; all outputs 0; acc arrays, init bits, scoreboard and valid/index delay lines cleared.
- FSM: IDLE -> ISSUE on i_start (ignored while busy). ISSUE -> DRAIN after last pair is issued. DRAIN -> DUMP when no pair is in flight. DUMP -> IDLE after beat n-1 is accepted. o_done pulses in the IDLE-entry cycle.
- Order: j outer 0..n-1, i inner 0..n-1, skipping i==j. Exactly n(n-1) issues.
- Scoreboard busy[i]: set at issue, cleared on the result-capture edge for that i. Issue is blocked while busy[i]=1, including the capture cycle. While blocked: o_rd_en=0, indices held, and a bubble enters the delay line. Guaranteed issue gap for the same i is at least RES_LAT+1.
- Delay line (valid, i) of depth RES_LAT.
  - At tap ACC_TAP, with valid set: o_acc_x/y = acc[i] if init[i], else 0. With valid clear: o_acc_x/y = 0.
  - At tap RES_LAT, with valid set: acc[i] <= i_res; init[i] <= 1.
- Start: all init bits cleared; acc values are not zeroed (init masks them).
- Edge cases:
  - n=0: ISSUE/DRAIN/DUMP skipped; o_done pulses 2 cycles after start; busy high for that interval.
  - n=1: no issues; one dump beat with value 0.
  - n > N_MAX: clamped to N_MAX.
- DUMP: beats idx 0..n-1 in order. Output is acc[idx] if init[idx], else 0. Valid holds with data stable until ready. No beat is dropped under ready backpressure.
- Reset mid-operation returns to IDLE immediately. No done pulse; in-flight results are discarded.
- Datapath is free-running; the scheduler never stalls it, only inserts bubbles.

Test Plan:
- n=2, stub datapath res=acc_in+1.0: issues (i1,j0) at t0, (i0,j1) at t0+1. Dump beats {0,0x3F800000},{1,0x3F800000}. Done asserted.
- n=3, same stub: 6 issues. (i2,j1) stalls until (i2,j0) capture+1 (gap 25 cycles). All dumps 0x40000000. Issue count checked.
- n=4, stub: issue timestamps per i differ by at least 25. Each acc tap shows the previous sum (0, 1.0, 2.0). Final 0x40400000 ×4.
- Dump backpressure: ready toggles 1,0,0,1 per cycle. Beats arrive in order with stable data while stalled. Done follows 1 cycle after last accept.
- n=0 and n=1: n=0 gives no rd_en and done; n=1 gives one beat of 0, then done. A start pulse while busy is ignored.
- Assert i_rst low mid-ISSUE with n=8: outputs 0 asynchronously. A new start with n=2 after release produces clean results with no stale acc.

Source files
------------

// File: rtl/accel_pair_scheduler.sv
// Purpose: sequences (i,j) body pairs through the pairwise acceleration datapath,
//          feeds each body's running sum back at the accumulate tap and streams
//          the final per-body accelerations out.
// Latency: accumulate tap ACC_TAP cycles after issue, result capture RES_LAT cycles
//          after issue; done pulses one cycle after the last dump beat is accepted.
// Backpressure: the datapath never stalls (bubbles only); dump beats hold on !i_out_ready.
// Ports:
//   i_clk, i_rst (async active-low), i_start, i_n_bodies       : control
//   o_busy, o_done                                              : status
//   o_rd_i, o_rd_j, o_rd_en                                     : body-memory pair issue
//   o_acc_x/y (to datapath), i_res_x/y (from datapath)          : accumulate loop
//   o_out_valid, i_out_ready, o_out_idx, o_out_ax/ay            : per-body dump stream
module accel_pair_scheduler #(
  parameter int N_MAX   = 64,
  parameter int IDX_W   = 6,
  parameter int ACC_TAP = 20,
  parameter int RES_LAT = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [IDX_W:0]   i_n_bodies,
  output logic             o_busy,
  output logic             o_done,
  output logic [IDX_W-1:0] o_rd_i,
  output logic [IDX_W-1:0] o_rd_j,
  output logic             o_rd_en,
  output logic [31:0]      o_acc_x,
  output logic [31:0]      o_acc_y,
  input  logic [31:0]      i_res_x,
  input  logic [31:0]      i_res_y,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [IDX_W-1:0] o_out_idx,
  output logic [31:0]      o_out_ax,
  output logic [31:0]      o_out_ay
);

  localparam int NW = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DUMP} state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [NW-1:0]    n_q, n_clamp;
  logic [NW-1:0]    cur_i, cur_j, nxt_i, nxt_j;
  logic [NW-1:0]    dump_idx;
  logic [N_MAX-1:0] sb_busy;
  logic [N_MAX-1:0] init_q;
  logic [31:0]      acc_x [N_MAX];
  logic [31:0]      acc_y [N_MAX];

  // Stage k (1-based) of the delay line sits at index k-1: it holds the pair
  // issued k cycles earlier.
  logic [RES_LAT-1:0] dl_vld;
  logic [IDX_W-1:0]   dl_idx [RES_LAT];

  logic             issue_en, last_pair, dump_fire, dump_last;
  logic [IDX_W-1:0] rd_i, tap_idx, cap_idx, out_idx;

  assign n_clamp = (i_n_bodies > NW'(N_MAX)) ? NW'(N_MAX) : i_n_bodies;
  assign rd_i    = cur_i[IDX_W-1:0];
  assign tap_idx = dl_idx[ACC_TAP-1];
  assign cap_idx = dl_idx[RES_LAT-1];
  assign out_idx = dump_idx[IDX_W-1:0];

  // The busy bit stays set through the capture cycle itself, so a repeat of the
  // same acted-on body is issued no earlier than RES_LAT+1 cycles later and its
  // accumulate tap always sees the freshly captured sum.
  assign issue_en  = (state_q == S_ISSUE) && !sb_busy[rd_i];
  assign last_pair = (cur_j == n_q - NW'(1)) && (cur_i == n_q - NW'(2));
  assign dump_fire = (state_q == S_DUMP) && i_out_ready;
  assign dump_last = (dump_idx == n_q - NW'(1));

  // Next pair: i inner, j outer, skipping the diagonal.
  always_comb begin
    nxt_i = cur_i + NW'(1);
    nxt_j = cur_j;
    if (nxt_i == n_q) begin
      nxt_i = '0;
      nxt_j = cur_j + NW'(1);
    end else if (nxt_i == cur_j) begin
      nxt_i = cur_i + NW'(2);
      if (nxt_i == n_q) begin
        nxt_i = '0;
        nxt_j = cur_j + NW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:
        if (i_start) state_d = (n_clamp < NW'(2)) ? S_DRAIN : S_ISSUE;
      S_ISSUE:
        if (issue_en && last_pair) state_d = S_DRAIN;
      S_DRAIN:
        if (dl_vld == '0) begin
          // An empty set has nothing to dump and finishes straight from here.
          if (n_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DUMP;
          end
        end
      S_DUMP:
        if (dump_fire && dump_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      n_q      <= '0;
      cur_i    <= '0;
      cur_j    <= '0;
      dump_idx <= '0;
      sb_busy  <= '0;
      init_q   <= '0;
      dl_vld   <= '0;
      for (int k = 0; k < RES_LAT; k++) dl_idx[k] <= '0;
      for (int b = 0; b < N_MAX; b++) begin
        acc_x[b] <= '0;
        acc_y[b] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;

      if (state_q == S_IDLE && i_start) begin
        n_q      <= n_clamp;
        cur_i    <= NW'(1);
        cur_j    <= '0;
        dump_idx <= '0;
        init_q   <= '0;  // stale sums are masked rather than zeroed
      end

      if (issue_en && !last_pair) begin
        cur_i <= nxt_i;
        cur_j <= nxt_j;
      end

      // Bubbles enter the line whenever nothing is issued.
      dl_vld    <= {dl_vld[RES_LAT-2:0], issue_en};
      dl_idx[0] <= rd_i;
      for (int k = 1; k < RES_LAT; k++) dl_idx[k] <= dl_idx[k-1];

      if (dl_vld[RES_LAT-1]) begin
        sb_busy[cap_idx] <= 1'b0;
        acc_x[cap_idx]   <= i_res_x;
        acc_y[cap_idx]   <= i_res_y;
        init_q[cap_idx]  <= 1'b1;
      end
      if (issue_en) sb_busy[rd_i] <= 1'b1;

      if (dump_fire && !dump_last) dump_idx <= dump_idx + NW'(1);
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_rd_i      = rd_i;
  assign o_rd_j      = cur_j[IDX_W-1:0];
  assign o_rd_en     = issue_en;
  assign o_acc_x     = (dl_vld[ACC_TAP-1] && init_q[tap_idx]) ? acc_x[tap_idx] : '0;
  assign o_acc_y     = (dl_vld[ACC_TAP-1] && init_q[tap_idx]) ? acc_y[tap_idx] : '0;
  assign o_out_valid = (state_q == S_DUMP);
  assign o_out_idx   = out_idx;
  assign o_out_ax    = (o_out_valid && init_q[out_idx]) ? acc_x[out_idx] : '0;
  assign o_out_ay    = (o_out_valid && init_q[out_idx]) ? acc_y[out_idx] : '0;

endmodule
